bus_bridge: RTL and testbench

- Sits between the CPU memory stage and the memory-mapped devices: data memory, timer, digital tube controller, switch input and LED output.
- Decodes the address, generates per-device byte enables, and places store data onto the correct byte lanes.
- Flags address-error exceptions.
- Registers the read path for one cycle, then returns extended load data to the writeback stage.

---
 rtl/bus_bridge_pkg.sv | 46 ++++
 rtl/bus_bridge_if.sv | 38 +++
 rtl/bus_bridge_load_ext.sv | 34 +++
 rtl/bus_bridge.sv | 122 ++++++++++++
 tb/tb_bus_bridge.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared encodings and address map for the memory-stage bus bridge.
// Store/load encodings are also consumed by the CPU decoder.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } store_t;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } load_t;

    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_DM    = 3'd1,
        SEL_TIMER = 3'd2,
        SEL_TUBE  = 3'd3,
        SEL_SW    = 3'd4,
        SEL_LED   = 3'd5
    } sel_t;

    localparam logic [31:0] DM_TOP     = 32'h0000_2FFF;
    localparam logic [31:0] TIMER_BASE = 32'h0000_7F00;
    localparam logic [31:0] TIMER_SIZE = 32'd12;
    localparam logic [31:0] TUBE_BASE  = 32'h0000_7F50;
    localparam logic [31:0] TUBE_SIZE  = 32'd8;
    localparam logic [31:0] SW_BASE    = 32'h0000_7F60;
    localparam logic [31:0] SW_SIZE    = 32'd8;
    localparam logic [31:0] LED_BASE   = 32'h0000_7F70;
    localparam logic [31:0] LED_SIZE   = 32'd4;

    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/bus_bridge_if.sv
// Memory-stage bus between the CPU, the bridge and the memory-mapped devices.
interface bus_bridge_if;
    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_store;
    logic [2:0]  m_load;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dm_byteen;
    logic [3:0]  timer_byteen;
    logic [3:0]  tube_byteen;
    logic [3:0]  led_byteen;
    logic [31:0] dm_rdata;
    logic [31:0] timer_rdata;
    logic [31:0] tube_rdata;
    logic [31:0] sw_rdata;
    logic [31:0] led_rdata;
    logic [31:0] w_load_data;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_store, m_load,
        input  dm_rdata, timer_rdata, tube_rdata, sw_rdata, led_rdata,
        output exc_adel, exc_ades, dev_addr, dev_wdata,
        output dm_byteen, timer_byteen, tube_byteen, led_byteen,
        output w_load_data
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_store, m_load,
        output dm_rdata, timer_rdata, tube_rdata, sw_rdata, led_rdata,
        input  exc_adel, exc_ades, dev_addr, dev_wdata,
        input  dm_byteen, timer_byteen, tube_byteen, led_byteen,
        input  w_load_data
    );
endinterface

// File: rtl/bus_bridge_load_ext.sv
// Byte/halfword extraction and sign/zero extension of load data.
module load_ext
    import bridge_pkg::*;
(
    input  load_t       load_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];

        data_o = '0;
        case (load_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'd0, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'd0, half_sel};
            LD_LW:   data_o = raw_i;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/bus_bridge.sv
// Address decode, store lane steering, address-error detection and a
// one-cycle registered read return for the memory-mapped devices.
module bus_bridge
    import bridge_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    bus_bridge_if.slave bus
);

    store_t      st;
    load_t       ld;
    sel_t        sel;
    logic [3:0]  lane_en;
    logic        mis_st;
    logic        mis_ld;
    logic        timer_cnt;
    logic        ades;
    logic        adel;
    logic        en_ok;
    logic [31:0] io_rdata;
    logic [31:0] raw;

    sel_t        sel_q, sel_d;
    load_t       load_q, load_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] io_rdata_q, io_rdata_d;

    assign st = store_t'(bus.m_store);
    assign ld = load_t'(bus.m_load);

    always_comb begin
        sel = SEL_NONE;
        if (bus.m_addr <= DM_TOP)                              sel = SEL_DM;
        else if (in_window(bus.m_addr, TIMER_BASE, TIMER_SIZE)) sel = SEL_TIMER;
        else if (in_window(bus.m_addr, TUBE_BASE, TUBE_SIZE))   sel = SEL_TUBE;
        else if (in_window(bus.m_addr, SW_BASE, SW_SIZE))       sel = SEL_SW;
        else if (in_window(bus.m_addr, LED_BASE, LED_SIZE))     sel = SEL_LED;
    end

    always_comb begin
        lane_en       = 4'b0000;
        bus.dev_wdata = bus.m_wdata;
        case (st)
            ST_SB: begin
                bus.dev_wdata = {4{bus.m_wdata[7:0]}};
                lane_en       = 4'b0001 << bus.m_addr[1:0];
            end
            ST_SH: begin
                bus.dev_wdata = {2{bus.m_wdata[15:0]}};
                lane_en       = bus.m_addr[1] ? 4'b1100 : 4'b0011;
            end
            ST_SW:   lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign mis_st = ((st == ST_SH) && bus.m_addr[0]) ||
                    ((st == ST_SW) && (bus.m_addr[1:0] != 2'b00));
    assign mis_ld = (((ld == LD_LH) || (ld == LD_LHU)) && bus.m_addr[0]) ||
                    ((ld == LD_LW) && (bus.m_addr[1:0] != 2'b00));
    // Timer offset 8 is the free-running count; it is read-only.
    assign timer_cnt = (sel == SEL_TIMER) && (bus.m_addr[3:2] == 2'b10);

    assign ades = bus.m_valid && (st != ST_NONE) &&
                  (mis_st || (sel == SEL_NONE) || (sel == SEL_SW) || timer_cnt ||
                   (((sel == SEL_TIMER) || (sel == SEL_TUBE)) && (st != ST_SW)));
    assign adel = bus.m_valid && (ld != LD_NONE) && !ades &&
                  (mis_ld || (sel == SEL_NONE) ||
                   (((sel == SEL_TIMER) || (sel == SEL_TUBE)) && (ld != LD_LW)));

    assign bus.exc_ades = ades;
    assign bus.exc_adel = adel;
    assign bus.dev_addr = bus.m_addr;

    // Byte enables are held off during reset so devices cannot be written.
    assign en_ok            = rst_n && bus.m_valid && !ades;
    assign bus.dm_byteen    = (en_ok && (sel == SEL_DM))    ? lane_en : 4'b0000;
    assign bus.timer_byteen = (en_ok && (sel == SEL_TIMER)) ? lane_en : 4'b0000;
    assign bus.tube_byteen  = (en_ok && (sel == SEL_TUBE))  ? lane_en : 4'b0000;
    assign bus.led_byteen   = (en_ok && (sel == SEL_LED))   ? lane_en : 4'b0000;

    always_comb begin
        case (sel)
            SEL_TIMER: io_rdata = bus.timer_rdata;
            SEL_TUBE:  io_rdata = bus.tube_rdata;
            SEL_SW:    io_rdata = bus.sw_rdata;
            SEL_LED:   io_rdata = bus.led_rdata;
            default:   io_rdata = 32'd0;
        endcase
    end

    assign sel_d      = sel;
    assign load_d     = (bus.m_valid && !adel) ? ld : LD_NONE;
    assign addr_lo_d  = bus.m_addr[1:0];
    assign io_rdata_d = io_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= SEL_NONE;
            load_q     <= LD_NONE;
            addr_lo_q  <= 2'd0;
            io_rdata_q <= 32'd0;
        end else begin
            sel_q      <= sel_d;
            load_q     <= load_d;
            addr_lo_q  <= addr_lo_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    // Data memory answers one cycle late on its own port; devices were sampled.
    assign raw = (sel_q == SEL_DM) ? bus.dm_rdata : io_rdata_q;

    load_ext u_load_ext (
        .load_i    (load_q),
        .addr_lo_i (addr_lo_q),
        .raw_i     (raw),
        .data_o    (bus.w_load_data)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Directed vector bench for bus_bridge: one vector per cycle, plus reset sequences.
module tb_bus_bridge;

    logic clk;
    logic rst_n;

    bus_bridge_if b ();

    bus_bridge dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  st;
        logic [2:0]  ld;
        logic [31:0] dm_rd;
        logic [1:0]  iodev;
        logic [31:0] io_rd;
        logic        e_adel;
        logic        e_ades;
        logic [15:0] e_ben;
        logic [31:0] e_wdata;
        logic [31:0] e_wld;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    int n_chk = 0;
    int n_err = 0;

    function automatic vec_t mk(logic v, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] st, logic [2:0] ld, logic [31:0] dm_rd,
                                logic [1:0] iodev, logic [31:0] io_rd,
                                logic e_adel, logic e_ades, logic [15:0] e_ben,
                                logic [31:0] e_wdata, logic [31:0] e_wld);
        vec_t r;
        r.v = v; r.addr = addr; r.wdata = wdata; r.st = st; r.ld = ld;
        r.dm_rd = dm_rd; r.iodev = iodev; r.io_rd = io_rd;
        r.e_adel = e_adel; r.e_ades = e_ades; r.e_ben = e_ben;
        r.e_wdata = e_wdata; r.e_wld = e_wld;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // The addressed device returns io_rd; every other device returns its complement.
    task automatic drive(input vec_t x);
        b.m_valid     = x.v;
        b.m_addr      = x.addr;
        b.m_wdata     = x.wdata;
        b.m_store     = x.st;
        b.m_load      = x.ld;
        b.dm_rdata    = x.dm_rd;
        b.timer_rdata = (x.iodev == 2'd0) ? x.io_rd : ~x.io_rd;
        b.tube_rdata  = (x.iodev == 2'd1) ? x.io_rd : ~x.io_rd;
        b.sw_rdata    = (x.iodev == 2'd2) ? x.io_rd : ~x.io_rd;
        b.led_rdata   = (x.iodev == 2'd3) ? x.io_rd : ~x.io_rd;
    endtask

    task automatic check_vec(input vec_t x, input int idx);
        chk("exc_adel",    idx, {31'd0, b.exc_adel}, {31'd0, x.e_adel});
        chk("exc_ades",    idx, {31'd0, b.exc_ades}, {31'd0, x.e_ades});
        chk("byteen",      idx, {16'd0, b.dm_byteen, b.timer_byteen, b.tube_byteen, b.led_byteen},
                                {16'd0, x.e_ben});
        chk("dev_wdata",   idx, b.dev_wdata, x.e_wdata);
        chk("dev_addr",    idx, b.dev_addr, x.addr);
        chk("w_load_data", idx, b.w_load_data, x.e_wld);
    endtask

    initial begin
        // byteen packing: {dm, timer, tube, led}
        vecs[0]  = mk(1, 32'h7F50, 32'h12345678, 2'd3, 3'd0, 32'h0,        2'd1, 32'h0,        0, 0, 16'h00F0, 32'h12345678, 32'h0);
        vecs[1]  = mk(1, 32'h7F50, 32'h0,        2'd0, 3'd5, 32'h0,        2'd1, 32'h12345678, 0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[2]  = mk(1, 32'h0003, 32'h000000A5, 2'd1, 3'd0, 32'h0,        2'd0, 32'h0,        0, 0, 16'h8000, 32'hA5A5A5A5, 32'h12345678);
        vecs[3]  = mk(1, 32'h0003, 32'h0,        2'd0, 3'd1, 32'h0,        2'd0, 32'h0,        0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[4]  = mk(1, 32'h0003, 32'h0,        2'd0, 3'd2, 32'hA5000000, 2'd0, 32'h0,        0, 0, 16'h0000, 32'h0,        32'hFFFFFFA5);
        vecs[5]  = mk(1, 32'h0002, 32'h0,        2'd0, 3'd3, 32'hA5000000, 2'd0, 32'h0,        0, 0, 16'h0000, 32'h0,        32'h000000A5);
        vecs[6]  = mk(1, 32'h0000, 32'h0,        2'd0, 3'd4, 32'h80017FFF, 2'd0, 32'h0,        0, 0, 16'h0000, 32'h0,        32'hFFFF8001);
        vecs[7]  = mk(1, 32'h0001, 32'h00001234, 2'd2, 3'd0, 32'h80017FFF, 2'd0, 32'h0,        0, 1, 16'h0000, 32'h12341234, 32'h00007FFF);
        vecs[8]  = mk(1, 32'h7F08, 32'h0,        2'd3, 3'd0, 32'h0,        2'd0, 32'h0,        0, 1, 16'h0000, 32'h0,        32'h0);
        vecs[9]  = mk(1, 32'h7F50, 32'h00000011, 2'd1, 3'd0, 32'h0,        2'd1, 32'h0,        0, 1, 16'h0000, 32'h11111111, 32'h0);
        vecs[10] = mk(1, 32'h4000, 32'h0,        2'd0, 3'd5, 32'h0,        2'd0, 32'h0,        1, 0, 16'h0000, 32'h0,        32'h0);
        vecs[11] = mk(1, 32'h7F54, 32'h0,        2'd0, 3'd1, 32'h0,        2'd1, 32'hCAFEBABE, 1, 0, 16'h0000, 32'h0,        32'h0);
        vecs[12] = mk(0, 32'h7F70, 32'hFFFFFFFF, 2'd3, 3'd0, 32'h0,        2'd3, 32'h55,       0, 0, 16'h0000, 32'hFFFFFFFF, 32'h0);
        vecs[13] = mk(0, 32'h7F70, 32'h0,        2'd0, 3'd5, 32'h0,        2'd3, 32'h55,       0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[14] = mk(1, 32'h7F70, 32'h0,        2'd0, 3'd5, 32'h0,        2'd3, 32'h55,       0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[15] = mk(1, 32'h7F72, 32'h0000BEEF, 2'd2, 3'd0, 32'h0,        2'd3, 32'h0,        0, 0, 16'h000C, 32'hBEEFBEEF, 32'h00000055);
        vecs[16] = mk(1, 32'h7F62, 32'h0,        2'd0, 3'd3, 32'h0,        2'd2, 32'h80001234, 0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[17] = mk(1, 32'h2FFC, 32'hAABBCCDD, 2'd3, 3'd0, 32'h0,        2'd0, 32'h0,        0, 0, 16'hF000, 32'hAABBCCDD, 32'hFFFF8000);
        vecs[18] = mk(1, 32'h3000, 32'h00000001, 2'd3, 3'd0, 32'h0,        2'd0, 32'h0,        0, 1, 16'h0000, 32'h00000001, 32'h0);
        vecs[19] = mk(1, 32'h7F08, 32'h0,        2'd0, 3'd5, 32'h0,        2'd0, 32'h99,       0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[20] = mk(1, 32'h7F04, 32'h00000007, 2'd3, 3'd0, 32'h0,        2'd0, 32'h0,        0, 0, 16'h0F00, 32'h00000007, 32'h00000099);
        vecs[21] = mk(1, 32'h7F61, 32'h0,        2'd1, 3'd0, 32'h0,        2'd2, 32'h0,        0, 1, 16'h0000, 32'h0,        32'h0);
        vecs[22] = mk(1, 32'h7F0C, 32'h0,        2'd0, 3'd5, 32'h0,        2'd0, 32'h0,        1, 0, 16'h0000, 32'h0,        32'h0);
        vecs[23] = mk(1, 32'h7F61, 32'h0,        2'd0, 3'd2, 32'h0,        2'd2, 32'h0000AB00, 0, 0, 16'h0000, 32'h0,        32'h0);
        vecs[24] = mk(1, 32'h0000, 32'h0,        2'd0, 3'd0, 32'h0,        2'd0, 32'h0,        0, 0, 16'h0000, 32'h0,        32'h000000AB);

        // Power-on reset with a valid LED store pending: byteen must stay off.
        rst_n = 1'b0;
        drive(mk(1, 32'h7F70, 32'hFFFFFFFF, 2'd3, 3'd0, 32'h0, 2'd3, 32'h0, 0, 0, 16'h0, 32'h0, 32'h0));
        #3;
        chk("rst_led_byteen", -1, {28'd0, b.led_byteen}, 32'h0);
        chk("rst_w_load",     -1, b.w_load_data, 32'h0);
        drive(mk(1, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0, 2'd0, 32'h0, 0, 0, 16'h0, 32'h0, 32'h0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i], i);
        end

        // Asynchronous reset mid-cycle after a switch load has returned.
        @(posedge clk);
        #1;
        drive(mk(1, 32'h7F60, 32'h0, 2'd0, 3'd5, 32'h0, 2'd2, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 32'h0));
        @(posedge clk);
        #1;
        chk("pre_rst_w_load", 100, b.w_load_data, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_w_load", 101, b.w_load_data, 32'h0);
        drive(mk(1, 32'h7F70, 32'h000000FF, 2'd3, 3'd0, 32'h0, 2'd2, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 32'h0));
        #1;
        chk("in_rst_led_byteen", 102, {28'd0, b.led_byteen}, 32'h0);
        chk("in_rst_dev_wdata",  103, b.dev_wdata, 32'h000000FF);
        @(posedge clk);
        #1;
        chk("in_rst_w_load", 104, b.w_load_data, 32'h0);
        drive(mk(1, 32'h7F60, 32'h0, 2'd0, 3'd5, 32'h0, 2'd2, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0, 32'h0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rel_w_load", 105, b.w_load_data, 32'h0);
        chk("post_rel_led_byteen", 106, {28'd0, b.led_byteen}, 32'h0);
        @(posedge clk);
        #1;
        chk("resume_w_load", 107, b.w_load_data, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
